// File: rtl/multi_road_phase_ctrl.sv
// Round-robin traffic-phase controller for N_ROADS approaches with a 2-digit BCD countdown.
// Optional all-red clearance phase after yellow is enabled by defining ALL_RED_EN.
module multi_road_phase_ctrl #(
    parameter int N_ROADS  = 2,
    parameter int T_GREEN  = 30,
    parameter int T_YELLOW = 5,
    parameter int T_ALLRED = 2,
    localparam int IW      = $clog2(N_ROADS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [N_ROADS-1:0]   car_req,
    output logic [3*N_ROADS-1:0] color,
    output logic [7:0]           count_bcd,
    output logic [IW-1:0]        active_idx,
    output logic                 phase_done
);

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
`ifdef ALL_RED_EN
    localparam logic [1:0] ST_ALLRED = 2'd2;
`endif

    if (N_ROADS < 2 || N_ROADS > 8) begin : g_bad_n
        $error("N_ROADS out of range 2..8");
    end
    if (T_GREEN < 1 || T_GREEN > 99 || T_YELLOW < 1 || T_YELLOW > 99 ||
        T_ALLRED < 1 || T_ALLRED > 99) begin : g_bad_t
        $error("phase length out of range 1..99");
    end

    function automatic logic [7:0] to_bcd(input int t);
        return {4'(t / 10), 4'(t % 10)};
    endfunction

    // Low digit borrows from the high digit when it underflows.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] pick_next(input logic [N_ROADS-1:0] req,
                                                input logic [IW-1:0] act);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = act;
        found = 1'b0;
        for (int k = 1; k < N_ROADS; k++) begin
            idx = (int'(act) + k) % N_ROADS;
            if (!found && req[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    function automatic logic [3*N_ROADS-1:0] color_of(input logic [1:0] st,
                                                     input logic [IW-1:0] act);
        logic [3*N_ROADS-1:0] c;
        for (int i = 0; i < N_ROADS; i++) begin
            if (st == ST_GREEN && act == IW'(i)) begin
                c[3*i +: 3] = 3'b100;
            end else if (st == ST_YELLOW && act == IW'(i)) begin
                c[3*i +: 3] = 3'b010;
            end else begin
                c[3*i +: 3] = 3'b001;
            end
        end
        return c;
    endfunction

    localparam logic [7:0] BCD_GREEN  = to_bcd(T_GREEN);
    localparam logic [7:0] BCD_YELLOW = to_bcd(T_YELLOW);
`ifdef ALL_RED_EN
    localparam logic [7:0] BCD_ALLRED = to_bcd(T_ALLRED);
`endif

    logic [1:0]           state_r;
    logic [N_ROADS-1:0]   pend_r;
    logic [IW-1:0]        next_r;
    logic [1:0]           state_nxt_s;
    logic [IW-1:0]        active_nxt_s;
    logic [IW-1:0]        next_nxt_s;
    logic [7:0]           count_nxt_s;
    logic                 done_nxt_s;
    logic [N_ROADS-1:0]   act_mask_s;
    logic [N_ROADS-1:0]   req_s;
    logic [N_ROADS-1:0]   pend_nxt_s;
    logic                 enter_green_s;

    // Phase sequencing: countdown, expiry decisions and next-road selection.
    always_comb begin
        state_nxt_s  = state_r;
        active_nxt_s = active_idx;
        next_nxt_s   = next_r;
        count_nxt_s  = count_bcd;
        done_nxt_s   = 1'b0;
        act_mask_s   = {{(N_ROADS-1){1'b0}}, 1'b1} << active_idx;
        req_s        = (pend_r | car_req) & ~act_mask_s;
        if (tick) begin
            if (count_bcd != 8'h00) begin
                count_nxt_s = bcd_dec(count_bcd);
            end else begin
                case (state_r)
                    ST_GREEN: begin
                        if (req_s == {N_ROADS{1'b0}}) begin
                            count_nxt_s = BCD_GREEN;
                        end else begin
                            state_nxt_s = ST_YELLOW;
                            count_nxt_s = BCD_YELLOW;
                            next_nxt_s  = pick_next(req_s, active_idx);
                            done_nxt_s  = 1'b1;
                        end
                    end
`ifdef ALL_RED_EN
                    ST_YELLOW: begin
                        state_nxt_s = ST_ALLRED;
                        count_nxt_s = BCD_ALLRED;
                        done_nxt_s  = 1'b1;
                    end
                    ST_ALLRED: begin
                        state_nxt_s  = ST_GREEN;
                        active_nxt_s = next_r;
                        count_nxt_s  = BCD_GREEN;
                        done_nxt_s   = 1'b1;
                    end
`else
                    ST_YELLOW: begin
                        state_nxt_s  = ST_GREEN;
                        active_nxt_s = next_r;
                        count_nxt_s  = BCD_GREEN;
                        done_nxt_s   = 1'b1;
                    end
`endif
                    default: begin
                        state_nxt_s  = ST_GREEN;
                        active_nxt_s = {IW{1'b0}};
                        count_nxt_s  = BCD_GREEN;
                        done_nxt_s   = 1'b0;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Request latch: collect waiting roads, drop the one that just got green.
    always_comb begin
        enter_green_s = (state_nxt_s == ST_GREEN) && (state_r != ST_GREEN);
        pend_nxt_s    = pend_r | (car_req & ~act_mask_s);
        if (enter_green_s) begin
            pend_nxt_s[active_nxt_s] = 1'b0;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_GREEN;
            pend_r     <= {N_ROADS{1'b0}};
            next_r     <= {IW{1'b0}};
            active_idx <= {IW{1'b0}};
            count_bcd  <= BCD_GREEN;
            phase_done <= 1'b0;
            color      <= color_of(ST_GREEN, {IW{1'b0}});
        end else begin
            state_r    <= state_nxt_s;
            pend_r     <= pend_nxt_s;
            next_r     <= next_nxt_s;
            active_idx <= active_nxt_s;
            count_bcd  <= count_nxt_s;
            phase_done <= done_nxt_s;
            color      <= color_of(state_nxt_s, active_nxt_s);
        end
    end

endmodule

// File: tb/tb_multi_road_phase_ctrl.sv
// Directed + randomized bench for multi_road_phase_ctrl against a decimal-count reference model.
// Works with or without ALL_RED_EN defined.
module tb_multi_road_phase_ctrl;

    localparam int N  = 4;
    localparam int TG = 12;
    localparam int TY = 3;
    localparam int TA = 2;

    logic           clk;
    logic           rst_n;
    logic           tick;
    logic [N-1:0]   car_req;
    logic [3*N-1:0] color;
    logic [7:0]     count_bcd;
    logic [1:0]     active_idx;
    logic           phase_done;

    int n_assert;
    int n_fail;

    // Reference model: phase 0=green 1=yellow 2=all-red, remaining ticks as an integer.
    int     m_phase;
    int     m_rem;
    int     m_active;
    int     m_next;
    bit     m_done;
    bit [N-1:0] m_pend;

    multi_road_phase_ctrl #(
        .N_ROADS (N),
        .T_GREEN (TG),
        .T_YELLOW(TY),
        .T_ALLRED(TA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .car_req   (car_req),
        .color     (color),
        .count_bcd (count_bcd),
        .active_idx(active_idx),
        .phase_done(phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dec_to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [3*N-1:0] model_color();
        logic [3*N-1:0] c;
        for (int i = 0; i < N; i++) begin
            if (i == m_active && m_phase == 0)      c[3*i +: 3] = 3'b100;
            else if (i == m_active && m_phase == 1) c[3*i +: 3] = 3'b010;
            else                                    c[3*i +: 3] = 3'b001;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_rem    = TG;
        m_active = 0;
        m_next   = 0;
        m_done   = 1'b0;
        m_pend   = '0;
    endtask

    task automatic model_step(input bit t, input bit [N-1:0] rq_in);
        bit [N-1:0] rq;
        int         old_act;
        bit         entered;
        old_act = m_active;
        entered = 1'b0;
        rq = m_pend | rq_in;
        rq[m_active] = 1'b0;
        m_done = 1'b0;
        if (t) begin
            if (m_rem > 0) begin
                m_rem--;
            end else if (m_phase == 0) begin
                if (rq == '0) begin
                    m_rem = TG;
                end else begin
                    for (int k = N - 1; k >= 1; k--)
                        if (rq[(m_active + k) % N]) m_next = (m_active + k) % N;
                    m_phase = 1;
                    m_rem   = TY;
                    m_done  = 1'b1;
                end
            end else if (m_phase == 1) begin
`ifdef ALL_RED_EN
                m_phase = 2;
                m_rem   = TA;
                m_done  = 1'b1;
`else
                entered = 1'b1;
`endif
            end else begin
                entered = 1'b1;
            end
        end
        if (entered) begin
            m_phase  = 0;
            m_active = m_next;
            m_rem    = TG;
            m_done   = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if (rq_in[i] && i != old_act) m_pend[i] = 1'b1;
        if (entered) m_pend[m_active] = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".color"}, 32'(color), 32'(model_color()));
        chk({tag, ".count"}, 32'(count_bcd), 32'(dec_to_bcd(m_rem)));
        chk({tag, ".active"}, 32'(active_idx), 32'(m_active));
        chk({tag, ".done"}, 32'(phase_done), 32'(m_done));
    endtask

    task automatic step(input string tag, input bit t, input bit [N-1:0] rq);
        tick    = t;
        car_req = rq;
        @(posedge clk);
        model_step(t, rq);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".color"}, 32'(color), 32'(12'b001_001_001_100));
        chk({tag, ".count"}, 32'(count_bcd), 32'(8'h12));
        chk({tag, ".active"}, 32'(active_idx), 32'd0);
        chk({tag, ".done"}, 32'(phase_done), 32'd0);
    endtask

    initial begin
        int greens[$];
        int budget;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tick     = 1'b0;
        car_req  = '0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // No requests: green extends (12..00 then 12) with no phase_done; covers 10->09 and 01->00.
        for (int i = 0; i < 15; i++) step("extend", 1'b1, '0);

        // Requests on roads 3 and 1 while road 0 green: served 1 then 3, road 2 never.
        step("req31", 1'b1, 4'b1010);
        for (int i = 0; i < 70; i++) begin
            step("order", 1'b1, '0);
            if (phase_done === 1'b1 && color[3*active_idx +: 3] === 3'b100)
                greens.push_back(int'(active_idx));
        end
        chk("order.count", 32'(greens.size()), 32'd2);
        if (greens.size() == 2) begin
            chk("order.first", 32'(greens[0]), 32'd1);
            chk("order.second", 32'(greens[1]), 32'd3);
        end

        // tick held low: outputs frozen, requests still latch.
        step("pre_hold", 1'b1, 4'b0001);
        for (int i = 0; i < 50; i++) step("hold", 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step("rand", ($urandom_range(0, 3) != 0),
                 {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});

        // Reach a yellow phase, then reset asynchronously in the middle of it.
        budget = 0;
        while (m_phase != 1 && budget < 300) begin
            step("to_yellow", 1'b1, (m_phase == 0) ? 4'b0110 : 4'b0000);
            budget++;
        end
        chk("yellow_reached", 32'(m_phase), 32'd1);
        step("in_yellow", 1'b1, 4'b1000);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_reset");
        #2;
        rst_n = 1'b1;
        // Pending requests were discarded: green must simply extend.
        for (int i = 0; i < 16; i++) step("post_reset", 1'b1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
